img_search_seq: RTL

Sequencer and scorer for the 16×16 template lookup (`IMG_SEARCH`, `HALVING`=4, 3-cycle registered latency). On `iSTART` it accepts 256 camera pixels in raster order through a valid/ready handshake. For each pixel it drives the matching template cell coordinate to the lookup and realigns the pixel with the returned template value. It accumulates the sum of absolute differences (SAD) and reports the score plus a match flag against a threshold. It sits between the camera pixel path and the template ROM.

---
 rtl/img_search_seq_if.sv | 25 ++
 rtl/img_search_seq.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/img_search_seq_if.sv
// Bundle of the pixel handshake, template-lookup and result signals for img_search_seq.
// The block uses the slave modport; the environment (camera path, ROM, host) uses master.
interface img_search_seq_if;
    logic        iSTART;
    logic [9:0]  iPIX;
    logic        iPIX_VAL;
    logic        oPIX_RDY;
    logic [12:0] oX;
    logic [12:0] oY;
    logic [9:0]  iTVAL;
    logic [17:0] oSAD;
    logic        oMATCH;
    logic        oDONE;
    logic        oBUSY;

    modport slave (
        input  iSTART, iPIX, iPIX_VAL, iTVAL,
        output oPIX_RDY, oX, oY, oSAD, oMATCH, oDONE, oBUSY
    );

    modport master (
        output iSTART, iPIX, iPIX_VAL, iTVAL,
        input  oPIX_RDY, oX, oY, oSAD, oMATCH, oDONE, oBUSY
    );
endinterface

// File: rtl/img_search_seq.sv
// Template-match sequencer: walks the 16x16 cell grid in step with accepted camera
// pixels, realigns each pixel with the registered template value coming back from the
// lookup, and accumulates the sum of absolute differences into a final score.
module img_search_seq #(
    parameter int          HALVING = 4,
    parameter int          LAT     = 3,
    parameter logic [17:0] THRESH  = 18'd20000
) (
    input logic             iCLK,
    input logic             iRST_N,
    img_search_seq_if.slave bus
);
    localparam int PAD = 13 - 4 - HALVING;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  cnt;
    logic        start;
    logic        accept;
    logic        last_beat;
    logic        upstream_empty;
    logic        final_acc;
    logic        vld_p [LAT];
    logic [9:0]  pix_p [LAT];
    logic [17:0] acc;
    logic [17:0] sum;
    logic [17:0] sad;
    logic        match;
    logic        done;

    // Magnitude of an 11-bit signed pixel/template difference, widened to the accumulator.
    function automatic logic [17:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic signed [10:0] d;
        logic [10:0]        mag;
        d   = $signed({1'b0, a}) - $signed({1'b0, b});
        mag = d[10] ? $unsigned(-d) : $unsigned(d);
        return {7'd0, mag};
    endfunction

    assign start     = (state == IDLE) && bus.iSTART;
    assign accept    = (state == RUN) && bus.iPIX_VAL;
    assign last_beat = accept && (cnt == 8'd255);
    assign sum       = acc + abs_diff(pix_p[LAT-1], bus.iTVAL);
    // The final beat is the only valid entry left once every earlier stage has emptied.
    assign final_acc = (state == DRAIN) && vld_p[LAT-1] && upstream_empty;

    assign bus.oPIX_RDY = (state == RUN);
    assign bus.oBUSY    = (state != IDLE);
    assign bus.oX       = {{PAD{1'b0}}, cnt[3:0], {HALVING{1'b0}}};
    assign bus.oY       = {{PAD{1'b0}}, cnt[7:4], {HALVING{1'b0}}};
    assign bus.oSAD     = sad;
    assign bus.oMATCH   = match;
    assign bus.oDONE    = done;

    // Check whether any delay stage ahead of the last one still carries a beat.
    always_comb begin
        upstream_empty = 1'b1;
        for (int i = 0; i < LAT - 1; i++) begin
            if (vld_p[i]) begin
                upstream_empty = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start, last accept, and final accumulate drive the transitions.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.iSTART) state_next = RUN;
            RUN:     if (last_beat)  state_next = DRAIN;
            DRAIN:   if (final_acc)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Delay-line valids: a cycle without an accept inserts a bubble.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            for (int i = 0; i < LAT; i++) begin
                vld_p[i] <= 1'b0;
            end
        end else begin
            vld_p[0] <= accept;
            for (int i = 1; i < LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Delay-line pixel data, qualified by the valids so it needs no reset.
    always_ff @(posedge iCLK) begin
        pix_p[0] <= bus.iPIX;
        for (int i = 1; i < LAT; i++) begin
            pix_p[i] <= pix_p[i-1];
        end
    end

    // Cell counter, SAD accumulator and the result registers loaded on the final beat.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            cnt   <= 8'd0;
            acc   <= 18'd0;
            sad   <= 18'd0;
            match <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= final_acc;
            if (start) begin
                cnt <= 8'd0;
                acc <= 18'd0;
            end else begin
                if (accept) begin
                    cnt <= cnt + 8'd1;
                end
                if (vld_p[LAT-1]) begin
                    acc <= sum;
                end
            end
            if (final_acc) begin
                sad   <= sum;
                match <= (sum <= THRESH);
            end
        end
    end
endmodule
